// File: rtl/bk_adder_pkg.sv
// Shared types and widths for the Brent-Kung adder BIST engine.
package bk_adder_pkg;

  localparam int ADDER_W  = 32;
  localparam int RESULT_W = 33;
  localparam int ERR_W    = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/bk_adder_bist_seq.sv
// j/k/cin sweep counter: k is the inner index, cin the outermost.
// Exposes the next vector and flags the final vector of the sweep.
module bk_bist_seq #(
  parameter int N_BITS    = 5,
  parameter int CIN_SWEEP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [N_BITS-1:0] j_nxt,
  output logic [N_BITS-1:0] k_nxt,
  output logic              cin_nxt,
  output logic              last
);

  localparam logic [N_BITS-1:0] IDX_MAX = '1;

  logic [N_BITS-1:0] j;
  logic [N_BITS-1:0] k;
  logic              cin;
  logic              k_wrap;
  logic              jk_wrap;

  always_comb begin
    k_wrap  = (k == IDX_MAX);
    jk_wrap = k_wrap && (j == IDX_MAX);
    k_nxt   = k + 1'b1;
    j_nxt   = k_wrap ? j + 1'b1 : j;
    cin_nxt = (CIN_SWEEP != 0 && jk_wrap) ? ~cin : cin;
    last    = jk_wrap && (CIN_SWEEP == 0 || cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j   <= '0;
      k   <= '0;
      cin <= 1'b0;
    end else if (clear) begin
      j   <= '0;
      k   <= '0;
      cin <= 1'b0;
    end else if (advance) begin
      j   <= j_nxt;
      k   <= k_nxt;
      cin <= cin_nxt;
    end
  end

endmodule

// File: rtl/bk_adder_bist.sv
// BIST engine for the 32-bit Brent-Kung adder: sweeps an operand grid,
// checks {cout,sum} against a reference add and records the first failure.
module bk_adder_bist
  import bk_adder_pkg::*;
#(
  parameter int              N_BITS      = 5,
  parameter logic [31:0]     HI_A        = 32'd0,
  parameter logic [31:0]     HI_B        = 32'd0,
  parameter int              SETTLE      = 2,
  parameter int              CIN_SWEEP   = 0,
  parameter int              STOP_ON_ERR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDER_W-1:0]  dut_a,
  output logic [ADDER_W-1:0]  dut_b,
  output logic                dut_cin,
  input  logic [ADDER_W-1:0]  dut_sum,
  input  logic                dut_cout,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDER_W-1:0]  fail_a,
  output logic [ADDER_W-1:0]  fail_b,
  output logic                fail_cin,
  output logic [RESULT_W-1:0] fail_got
);

  localparam int               HI_W       = ADDER_W - N_BITS;
  localparam logic [HI_W-1:0]  HI_A_BITS  = HI_A[HI_W-1:0];
  localparam logic [HI_W-1:0]  HI_B_BITS  = HI_B[HI_W-1:0];
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ERR_W-1:0]     err_nxt;
  logic                 clear, advance, capture;
  logic [N_BITS-1:0]    j_nxt, k_nxt;
  logic                 cin_nxt, last;
  logic [RESULT_W-1:0]  expected, got;
  logic                 mismatch;

  bk_bist_seq #(
    .N_BITS    (N_BITS),
    .CIN_SWEEP (CIN_SWEEP)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .j_nxt   (j_nxt),
    .k_nxt   (k_nxt),
    .cin_nxt (cin_nxt),
    .last    (last)
  );

  always_comb begin
    expected = {1'b0, dut_a} + {1'b0, dut_b} + RESULT_W'(dut_cin);
    got      = {dut_cout, dut_sum};
    mismatch = (state == S_CHECK) && (got != expected);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_count;
    clear     = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          clear     = 1'b1;
          err_nxt   = '0;
          cnt_nxt   = SETTLE_LD;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_CHECK;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_count != '1) err_nxt = err_count + 1'b1;
          capture = (err_count == '0);
        end
        // A stopping mismatch freezes the operands on the failing vector.
        if (mismatch && STOP_ON_ERR != 0) begin
          state_nxt = S_FAIL;
        end else if (last) begin
          state_nxt = S_DONE;
        end else begin
          advance   = 1'b1;
          cnt_nxt   = SETTLE_LD;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_cin   <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
      fail_got  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      err_count <= err_nxt;
      busy      <= (state_nxt == S_WAIT) || (state_nxt == S_CHECK);
      done      <= (state_nxt == S_DONE) || (state_nxt == S_FAIL);
      pass      <= (state_nxt == S_DONE) && (err_nxt == '0);
      if (clear) begin
        dut_a    <= {HI_A_BITS, {N_BITS{1'b0}}};
        dut_b    <= {HI_B_BITS, {N_BITS{1'b0}}};
        dut_cin  <= 1'b0;
        fail_a   <= '0;
        fail_b   <= '0;
        fail_cin <= 1'b0;
        fail_got <= '0;
      end else begin
        if (advance) begin
          dut_a   <= {HI_A_BITS, j_nxt};
          dut_b   <= {HI_B_BITS, k_nxt};
          dut_cin <= cin_nxt;
        end
        if (capture) begin
          fail_a   <= dut_a;
          fail_b   <= dut_b;
          fail_cin <= dut_cin;
          fail_got <= got;
        end
      end
    end
  end

endmodule

// File: tb/tb_bk_adder_bist.sv
// Scoreboard bench for bk_adder_bist: three engines beside behavioural
// adders (good / sum bit 3 stuck low / cout stuck low), directed runs.
module tb_bk_adder_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_r = '0;
  logic        fault0 = 1'b0;

  logic [2:0]  busy_w, done_w, pass_w, dc_w, fc_w, cout_w;
  logic [15:0] err_w [3];
  logic [31:0] da_w [3];
  logic [31:0] db_w [3];
  logic [31:0] fa_w [3];
  logic [31:0] fb_w [3];
  logic [31:0] sum_w [3];
  logic [32:0] fg_w [3];
  logic [32:0] r0, r1, r2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          id;
    int          cycles;
    logic        pass;
    logic [15:0] err;
    logic [31:0] fa;
    logic [31:0] fb;
    logic        fc;
    logic [32:0] fg;
    logic [31:0] da;
    logic [31:0] db;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [32:0] add33(logic [31:0] a, logic [31:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  assign r0 = add33(da_w[0], db_w[0], dc_w[0]);
  assign r1 = add33(da_w[1], db_w[1], dc_w[1]);
  assign r2 = add33(da_w[2], db_w[2], dc_w[2]);
  assign {cout_w[0], sum_w[0]} = fault0 ? (r0 & ~33'h8) : r0;
  assign {cout_w[1], sum_w[1]} = r1 & ~33'h8;
  assign {cout_w[2], sum_w[2]} = r2 & ~33'h1_0000_0000;

  bk_adder_bist u0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]),
    .dut_a(da_w[0]), .dut_b(db_w[0]), .dut_cin(dc_w[0]),
    .dut_sum(sum_w[0]), .dut_cout(cout_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .fail_a(fa_w[0]), .fail_b(fb_w[0]), .fail_cin(fc_w[0]), .fail_got(fg_w[0])
  );

  bk_adder_bist #(.STOP_ON_ERR(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]),
    .dut_a(da_w[1]), .dut_b(db_w[1]), .dut_cin(dc_w[1]),
    .dut_sum(sum_w[1]), .dut_cout(cout_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .fail_a(fa_w[1]), .fail_b(fb_w[1]), .fail_cin(fc_w[1]), .fail_got(fg_w[1])
  );

  bk_adder_bist #(.HI_A(32'h07FF_FFFF), .HI_B(32'h07FF_FFFF), .CIN_SWEEP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]),
    .dut_a(da_w[2]), .dut_b(db_w[2]), .dut_cin(dc_w[2]),
    .dut_sum(sum_w[2]), .dut_cout(cout_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
    .fail_a(fa_w[2]), .fail_b(fb_w[2]), .fail_cin(fc_w[2]), .fail_got(fg_w[2])
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per rising done and compares the record.
  logic prev_done [3];
  int   cyc [3];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cyc[i] = 0;
        prev_done[i] = 1'b0;
      end else begin
        if (busy_w[i]) cyc[i]++;
        if (done_w[i] && !prev_done[i]) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'(i), 64'hFF);
          end else begin
            e = sb.pop_front();
            chk("engine_id",  64'(i),         64'(e.id));
            chk("busy_cycles", 64'(cyc[i]),   64'(e.cycles));
            chk("pass",       64'(pass_w[i]), 64'(e.pass));
            chk("err_count",  64'(err_w[i]),  64'(e.err));
            chk("fail_a",     64'(fa_w[i]),   64'(e.fa));
            chk("fail_b",     64'(fb_w[i]),   64'(e.fb));
            chk("fail_cin",   64'(fc_w[i]),   64'(e.fc));
            chk("fail_got",   64'(fg_w[i]),   64'(e.fg));
            chk("hold_a",     64'(da_w[i]),   64'(e.da));
            chk("hold_b",     64'(db_w[i]),   64'(e.db));
          end
          cyc[i] = 0;
        end
        prev_done[i] = done_w[i];
      end
    end
  end

  task automatic chk_zero(input int i, input string tag);
    chk({tag, "_busy"}, 64'(busy_w[i]), 0);
    chk({tag, "_done"}, 64'(done_w[i]), 0);
    chk({tag, "_pass"}, 64'(pass_w[i]), 0);
    chk({tag, "_err"},  64'(err_w[i]),  0);
    chk({tag, "_da"},   64'(da_w[i]),   0);
    chk({tag, "_db"},   64'(db_w[i]),   0);
    chk({tag, "_dc"},   64'(dc_w[i]),   0);
    chk({tag, "_fa"},   64'(fa_w[i]),   0);
    chk({tag, "_fg"},   64'(fg_w[i]),   0);
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start_r[i] = 1'b1;
    @(negedge clk);
    start_r[i] = 1'b0;
  endtask

  // Run engine i to done; optionally re-pulse start at cycle poke.
  task automatic run(input int i, input int limit, input int poke);
    bit ok = 0;
    pulse_start(i);
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      start_r[i] = (c == poke);
      if (done_w[i]) begin ok = 1; break; end
    end
    start_r[i] = 1'b0;
    if (!ok) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    for (int c = 0; c < 4 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("scoreboard_drain", 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero(0, "reset");
    chk_zero(2, "reset2");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good adder, defaults; a start pulse mid-run must be ignored.
    sb.push_back('{0, 3072, 1'b1, 16'd0, 32'd0, 32'd0, 1'b0, 33'd0, 32'd31, 32'd31});
    run(0, 4000, 500);

    // Sum bit 3 stuck low, keep going: 512 of the 1024 sums have bit 3 set.
    fault0 = 1'b1;
    sb.push_back('{0, 3072, 1'b0, 16'd512, 32'd0, 32'd8, 1'b0, 33'd0, 32'd31, 32'd31});
    run(0, 4000, -1);
    fault0 = 1'b0;

    // Same fault, stop on error: vector (0,8) is the ninth, 9*3 busy cycles.
    sb.push_back('{1, 27, 1'b0, 16'd1, 32'd0, 32'd8, 1'b0, 33'd0, 32'd0, 32'd8});
    run(1, 100, -1);

    // High operands with cout stuck low: every vector of both cin passes fails.
    sb.push_back('{2, 6144, 1'b0, 16'd2048, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 1'b0,
                   33'h0_FFFF_FFC0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    run(2, 7000, -1);

    // Asynchronous reset mid-run, then a clean restart.
    pulse_start(0);
    repeat (300) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero(0, "midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb.push_back('{0, 3072, 1'b1, 16'd0, 32'd0, 32'd0, 1'b0, 33'd0, 32'd31, 32'd31});
    run(0, 4000, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
